// File: rtl/vfat_sbit_rate_monitor.sv
// vfat_sbit_rate_monitor
// Per-VFAT S-bit activity counter. The aligned S-bit bus is reduced to a
// masked, registered OR per VFAT; active clocks are counted over a
// programmable gate window. The per-window totals are latched for
// slow-control readback through a registered, addressed read port.
module vfat_sbit_rate_monitor #(
    parameter int MXSBITS    = 64,
    parameter int NVFAT      = 24,
    parameter int CNT_WIDTH  = 24,
    parameter int GATE_WIDTH = 26
) (
    input  logic                       clock,
    input  logic                       reset_i,
    input  logic [MXSBITS*NVFAT-1:0]   sbits,
    input  logic [NVFAT-1:0]           sbit_mask,
    input  logic [GATE_WIDTH-1:0]      gate_len,
    input  logic                       cnt_reset,
    input  logic [4:0]                 rd_addr,
    output logic [CNT_WIDTH-1:0]       rd_data,
    output logic                       rate_valid,
    output logic                       window_strobe,
    output logic [NVFAT-1:0]           vfat_or
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NVFAT-1:0]      vfatOr_d, vfatOr_q;
    logic [GATE_WIDTH-1:0] wcnt_d, wcnt_q;
    logic [CNT_WIDTH-1:0]  live_d    [NVFAT];
    logic [CNT_WIDTH-1:0]  live_q    [NVFAT];
    logic [CNT_WIDTH-1:0]  latched_d [NVFAT];
    logic [CNT_WIDTH-1:0]  latched_q [NVFAT];
    logic                  rateValid_d, rateValid_q;
    logic                  strobe_d, strobe_q;
    logic [CNT_WIDTH-1:0]  rdData_d, rdData_q;
    logic                  term;

    // Counters stick at all-ones instead of wrapping, so an overflowing
    // window still reads as "at least this many".
    function automatic logic [CNT_WIDTH-1:0] satInc(
        input logic [CNT_WIDTH-1:0] val,
        input logic                 hit
    );
        logic [CNT_WIDTH-1:0] res;
        res = val;
        if (hit && (val != CNT_MAX)) begin
            res = val + 1'b1;
        end
        return res;
    endfunction

    // Using >= lets a gate_len shortened mid-window close on the next clock
    // rather than waiting for the window counter to wrap.
    assign term = (wcnt_q >= gate_len);

    // Masked OR-reduction of each VFAT's S-bit slice.
    always_comb begin
        vfatOr_d = '0;
        for (int v = 0; v < NVFAT; v++) begin
            vfatOr_d[v] = (|sbits[v*MXSBITS +: MXSBITS]) & ~sbit_mask[v];
        end
    end

    // Window sequencing and live/latched counters; cnt_reset overrides a
    // closing window so no strobe escapes during a clear.
    always_comb begin
        wcnt_d      = wcnt_q + 1'b1;
        rateValid_d = rateValid_q;
        strobe_d    = 1'b0;
        live_d      = live_q;
        latched_d   = latched_q;
        if (cnt_reset) begin
            wcnt_d      = '0;
            rateValid_d = 1'b0;
            for (int v = 0; v < NVFAT; v++) begin
                live_d[v]    = '0;
                latched_d[v] = '0;
            end
        end else if (term) begin
            wcnt_d      = '0;
            rateValid_d = 1'b1;
            strobe_d    = 1'b1;
            for (int v = 0; v < NVFAT; v++) begin
                latched_d[v] = satInc(live_q[v], vfatOr_q[v]);
                live_d[v]    = '0;
            end
        end else begin
            for (int v = 0; v < NVFAT; v++) begin
                live_d[v] = satInc(live_q[v], vfatOr_q[v]);
            end
        end
    end

    // Read mux; addresses past the last VFAT read back as zero.
    always_comb begin
        rdData_d = '0;
        if (32'(rd_addr) < 32'(NVFAT)) begin
            rdData_d = latched_q[rd_addr];
        end
    end

    // State registers, all cleared asynchronously by reset_i.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            vfatOr_q    <= '0;
            wcnt_q      <= '0;
            rateValid_q <= 1'b0;
            strobe_q    <= 1'b0;
            rdData_q    <= '0;
            for (int v = 0; v < NVFAT; v++) begin
                live_q[v]    <= '0;
                latched_q[v] <= '0;
            end
        end else begin
            vfatOr_q    <= vfatOr_d;
            wcnt_q      <= wcnt_d;
            rateValid_q <= rateValid_d;
            strobe_q    <= strobe_d;
            rdData_q    <= rdData_d;
            live_q      <= live_d;
            latched_q   <= latched_d;
        end
    end

    assign vfat_or       = vfatOr_q;
    assign rate_valid    = rateValid_q;
    assign window_strobe = strobe_q;
    assign rd_data       = rdData_q;

endmodule

// File: tb/tb_vfat_sbit_rate_monitor.sv
// Self-checking bench for vfat_sbit_rate_monitor. A second instance with a
// 4-bit counter shares the inputs to exercise counter saturation.
module tb_vfat_sbit_rate_monitor;

    localparam int MX = 64;
    localparam int NV = 24;
    localparam int CW = 24;
    localparam int GW = 26;

    logic              clock;
    logic              reset_i;
    logic [MX*NV-1:0]  sbits;
    logic [NV-1:0]     sbit_mask;
    logic [GW-1:0]     gate_len;
    logic              cnt_reset;
    logic [4:0]        rd_addr;
    logic [CW-1:0]     rd_data;
    logic              rate_valid;
    logic              window_strobe;
    logic [NV-1:0]     vfat_or;

    logic [3:0]        rdDataSmall;
    logic              rateValidSmall;
    logic              strobeSmall;
    logic [NV-1:0]     vfatOrSmall;

    int total = 0;
    int bad   = 0;
    int expQ[$];
    int expSmallQ[$];

    vfat_sbit_rate_monitor #(.MXSBITS(MX), .NVFAT(NV), .CNT_WIDTH(CW), .GATE_WIDTH(GW)) dut (
        .clock(clock), .reset_i(reset_i), .sbits(sbits), .sbit_mask(sbit_mask),
        .gate_len(gate_len), .cnt_reset(cnt_reset), .rd_addr(rd_addr),
        .rd_data(rd_data), .rate_valid(rate_valid), .window_strobe(window_strobe),
        .vfat_or(vfat_or)
    );

    vfat_sbit_rate_monitor #(.MXSBITS(MX), .NVFAT(NV), .CNT_WIDTH(4), .GATE_WIDTH(GW)) dutSmall (
        .clock(clock), .reset_i(reset_i), .sbits(sbits), .sbit_mask(sbit_mask),
        .gate_len(gate_len), .cnt_reset(cnt_reset), .rd_addr(rd_addr),
        .rd_data(rdDataSmall), .rate_valid(rateValidSmall), .window_strobe(strobeSmall),
        .vfat_or(vfatOrSmall)
    );

    // 100 MHz-style free-running clock for simulation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulseCntReset();
        cnt_reset = 1'b1;
        tick();
        cnt_reset = 1'b0;
    endtask

    task automatic waitStrobe(input int expEdges, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!window_strobe && n < expEdges + 20);
        total++;
        if (!window_strobe || n != expEdges) begin
            bad++;
            $display("[TB] FAIL %s: strobe after %0d edges (seen=%0b), expected %0d", name, n, window_strobe, expEdges);
        end
    endtask

    task automatic checkRead(input string name);
        int exp;
        tick();
        exp = expQ.pop_front();
        total++;
        if (int'(rd_data) !== exp) begin
            bad++;
            $display("[TB] FAIL %s: rd_data=%0d expected %0d", name, rd_data, exp);
        end
    endtask

    task automatic test_reset();
        reset_i   = 1'b1;
        sbits     = '0;
        sbit_mask = '0;
        gate_len  = GW'(99);
        cnt_reset = 1'b0;
        rd_addr   = 5'd0;
        #12;
        total++;
        if ({rd_data, rate_valid, window_strobe, vfat_or} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: rd=%0d rv=%0b ws=%0b or=%h expected all 0", rd_data, rate_valid, window_strobe, vfat_or);
        end
        reset_i = 1'b0;
        tick();
        total++;
        if (rate_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_rate_valid_early: got %0b expected 0", rate_valid);
        end
        waitStrobe(99, "first_window_100");
        total++;
        if (rate_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rate_valid_set: got %0b expected 1", rate_valid);
        end
        expQ.push_back(0);
        checkRead("idle_read_0");
        total++;
        if (window_strobe !== 1'b0 || rate_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL strobe_pulse: ws=%0b rv=%0b expected ws=0 rv=1", window_strobe, rate_valid);
        end
        rd_addr = 5'd5;
        expQ.push_back(0);
        checkRead("idle_read_5");
        rd_addr = 5'd23;
        expQ.push_back(0);
        checkRead("idle_read_23");
    endtask

    task automatic test_count();
        sbits            = '0;
        sbits[3*MX + 17] = 1'b1;
        gate_len         = GW'(999);
        rd_addr          = 5'd3;
        total++;
        if (vfat_or !== '0) begin
            bad++;
            $display("[TB] FAIL or_latency_before: vfat_or=%h expected 0", vfat_or);
        end
        tick();
        total++;
        if (vfat_or !== NV'(24'h000008)) begin
            bad++;
            $display("[TB] FAIL or_latency_after: vfat_or=%h expected 000008", vfat_or);
        end
        pulseCntReset();
        total++;
        if (vfat_or[3] !== 1'b1 || rate_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cnt_reset_effects: or3=%0b rv=%0b expected or3=1 rv=0", vfat_or[3], rate_valid);
        end
        expQ.push_back(1000);
        waitStrobe(1000, "count_window");
        checkRead("count_vfat3");
        rd_addr = 5'd2;
        expQ.push_back(0);
        checkRead("count_vfat2");
    endtask

    task automatic test_mask();
        rd_addr   = 5'd3;
        sbit_mask = NV'(1) << 3;
        tick();
        total++;
        if (vfat_or !== '0) begin
            bad++;
            $display("[TB] FAIL mask_or: vfat_or=%h expected 0", vfat_or);
        end
        pulseCntReset();
        expQ.push_back(0);
        waitStrobe(1000, "mask_window");
        checkRead("mask_vfat3");
        pulseCntReset();
        repeat (400) tick();
        sbit_mask = '0;
        expQ.push_back(599);
        waitStrobe(600, "unmask_window");
        checkRead("unmask_vfat3");
    endtask

    task automatic test_saturate();
        int exp;
        int expSmall;
        sbits    = '0;
        sbits[5] = 1'b1;
        gate_len = GW'(99);
        rd_addr  = 5'd0;
        tick();
        pulseCntReset();
        expQ.push_back(100);
        expSmallQ.push_back(15);
        waitStrobe(100, "sat_window");
        tick();
        exp      = expQ.pop_front();
        expSmall = expSmallQ.pop_front();
        total++;
        if (int'(rd_data) !== exp) begin
            bad++;
            $display("[TB] FAIL sat_wide: rd_data=%0d expected %0d", rd_data, exp);
        end
        total++;
        if (int'(rdDataSmall) !== expSmall) begin
            bad++;
            $display("[TB] FAIL sat_narrow: rd_data=%0d expected %0d", rdDataSmall, expSmall);
        end
        rd_addr = 5'd24;
        expQ.push_back(0);
        checkRead("addr_24_zero");
        rd_addr = 5'd31;
        expQ.push_back(0);
        checkRead("addr_31_zero");
        rd_addr = 5'd0;
    endtask

    task automatic test_gate_change();
        gate_len = GW'(1000);
        pulseCntReset();
        repeat (500) tick();
        gate_len = GW'(10);
        expQ.push_back(501);
        waitStrobe(1, "gate_shrink_strobe");
        checkRead("gate_shrink_count");
        total++;
        if (window_strobe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gate_shrink_pulse: ws=%0b expected 0", window_strobe);
        end
        expQ.push_back(11);
        waitStrobe(10, "gate_next_window");
        checkRead("gate_next_count");
    endtask

    task automatic test_cnt_reset_term();
        pulseCntReset();
        repeat (10) tick();
        cnt_reset = 1'b1;
        tick();
        cnt_reset = 1'b0;
        total++;
        if (window_strobe !== 1'b0 || rate_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clr_vs_term: ws=%0b rv=%0b expected 0 0", window_strobe, rate_valid);
        end
        expQ.push_back(0);
        checkRead("clr_vs_term_read");
        expQ.push_back(11);
        waitStrobe(10, "clr_full_window");
        checkRead("clr_full_count");
        total++;
        if (rate_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL clr_rate_valid: got %0b expected 1", rate_valid);
        end
    endtask

    task automatic test_gate_zero();
        logic [11:0] pat;
        int exp;
        pat      = 12'b101100111010;
        gate_len = '0;
        rd_addr  = 5'd0;
        pulseCntReset();
        for (int i = 1; i <= 14; i++) begin
            if (i <= 12) begin
                sbits    = '0;
                sbits[5] = pat[i-1];
                expQ.push_back(int'(pat[i-1]));
            end
            tick();
            total++;
            if (window_strobe !== 1'b1) begin
                bad++;
                $display("[TB] FAIL gate0_strobe[%0d]: ws=%0b expected 1", i, window_strobe);
            end
            if (i >= 3) begin
                exp = expQ.pop_front();
                total++;
                if (int'(rd_data) !== exp) begin
                    bad++;
                    $display("[TB] FAIL gate0_count[%0d]: rd_data=%0d expected %0d", i, rd_data, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_window();
        sbits    = '0;
        sbits[5] = 1'b1;
        gate_len = GW'(99);
        pulseCntReset();
        repeat (50) tick();
        reset_i = 1'b1;
        #1;
        total++;
        if ({rd_data, rate_valid, window_strobe, vfat_or} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_async: rd=%0d rv=%0b ws=%0b or=%h expected all 0", rd_data, rate_valid, window_strobe, vfat_or);
        end
        repeat (3) tick();
        #2;
        reset_i = 1'b0;
        expQ.push_back(99);
        waitStrobe(100, "midreset_window");
        checkRead("midreset_count");
    endtask

    initial begin
        test_reset();
        test_count();
        test_mask();
        test_saturate();
        test_gate_change();
        test_cnt_reset_term();
        test_gate_zero();
        test_reset_mid_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
